// File: rtl/fpmul_pkg.sv
// Shared constants and FSM encoding for the floating-point multiplier arbiter.
// Holds the default sizing and the canonical quiet NaN returned when an operation is abandoned.
package fpmul_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 32;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    // Port-index width; a single-port build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting port after last_grant, wrapping.
// The loop runs from the farthest candidate down so the nearest one is assigned last and wins.
module rr_arbiter
    import fpmul_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, last_grant} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one external FP multiplier between N_REQ requesters, one operation at a time,
// with a WAIT-state watchdog that resets the multiplier and answers with a quiet NaN.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | no operation; pick a round-robin winner when any req is high
//   LOAD      | ack[winner] high, operands on mul_op1/mul_op2 settling
//   ISSUE     | mul_ready high for one cycle, watchdog counter cleared
//   WAIT      | waiting for mul_done, counter running toward TIMEOUT-1
//   RESP      | rsp_valid[winner] with the captured product
//   RECOVER   | mul_rst, rsp_valid[winner] with QNAN, err latched
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   op_a,
    input  logic [32*N_REQ-1:0]   op_b,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_res,
    output logic                  busy,
    output logic                  err,
    output logic                  mul_rst,
    output logic                  mul_ready,
    output logic [31:0]           mul_op1,
    output logic [31:0]           mul_op2,
    input  logic [31:0]           mul_res,
    input  logic                  mul_done
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner_q;
    logic [IW-1:0] rr_winner;
    logic          rr_valid;
    logic [CW-1:0] cnt;
    logic          rec_q;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .valid      (rr_valid),
        .winner     (rr_winner)
    );

    assign sel_a = op_a[32*rr_winner +: 32];
    assign sel_b = op_b[32*rr_winner +: 32];

    // The multiplier is held in reset whenever the arbiter is, not only on a timeout.
    assign mul_rst = rst | rec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= IW'(N_REQ - 1);
            winner_q   <= '0;
            cnt        <= '0;
            rec_q      <= 1'b0;
            ack        <= '0;
            rsp_valid  <= '0;
            rsp_res    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            mul_ready  <= 1'b0;
            mul_op1    <= '0;
            mul_op2    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rr_valid) begin
                        state      <= S_LOAD;
                        winner_q   <= rr_winner;
                        last_grant <= rr_winner;
                        ack        <= N_REQ'(1) << rr_winner;
                        mul_op1    <= sel_a;
                        mul_op2    <= sel_b;
                        busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    ack       <= '0;
                    mul_ready <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    mul_ready <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the final counted cycle still counts as success.
                    if (mul_done) begin
                        rsp_valid <= N_REQ'(1) << winner_q;
                        rsp_res   <= mul_res;
                        state     <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid <= N_REQ'(1) << winner_q;
                        rsp_res   <= QNAN;
                        err       <= 1'b1;
                        rec_q     <= 1'b1;
                        state     <= S_RECOVER;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP, S_RECOVER: begin
                    rsp_valid <= '0;
                    rsp_res   <= '0;
                    rec_q     <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: directed vector table, hand-written corner sequences and a random
// phase, all checked every cycle against a transaction-level timing model of the arbiter.
module tb_fpmul_arbiter;

    localparam int N  = 4;
    localparam int TO = 32;
    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [32*N-1:0]   op_a;
    logic [32*N-1:0]   op_b;
    logic [N-1:0]      ack;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_res;
    logic              busy;
    logic              err;
    logic              mul_rst;
    logic              mul_ready;
    logic [31:0]       mul_op1;
    logic [31:0]       mul_op2;
    logic [31:0]       mul_res;
    logic              mul_done;

    fpmul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_res   (rsp_res),
        .busy      (busy),
        .err       (err),
        .mul_rst   (mul_rst),
        .mul_ready (mul_ready),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .mul_res   (mul_res),
        .mul_done  (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: a few exact IEEE products, NaN for inf*0, a scramble otherwise.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4010_0000;
        if ((a == 32'h7F80_0000 && b == 32'h0) || (a == 32'h0 && b == 32'h7F80_0000)) return QNAN_C;
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E37_79B9;
    endfunction

    int   cur_lat;
    int   next_lat;
    int   dly;
    logic stray;

    assign mul_res  = ref_mul(mul_op1, mul_op2);
    assign mul_done = (dly == 1) || stray;

    always @(posedge clk or posedge rst) begin
        if (rst) dly <= 0;
        else if (mul_ready) dly <= cur_lat;
        else if (dly != 0) dly <= dly - 1;
    end

    function automatic int first_bit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Transaction model: one operation occupies [ack_cyc, rsp_cyc]; IDLE from rsp_cyc+1.
    int          cyc = 0;
    int          idle_from, ack_cyc, rsp_cyc, last_m, m_port, m_lat;
    logic        m_to, err_m;
    logic [31:0] m_a, m_b;
    logic [N-1:0] exp_ack, exp_rv;
    int          mrst_cnt = 0;

    int          grant_log[$];
    int          ack_cyc_log[$];
    logic [31:0] rsp_log[$];
    int          rsp_port_log[$];
    int          rsp_cyc_log[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            idle_from = cyc;
            ack_cyc   = -100;
            rsp_cyc   = -100;
            last_m    = N - 1;
            err_m     = 1'b0;
        end else begin
            exp_ack = '0;
            if (cyc - 1 >= idle_from && req != '0) begin
                m_port    = rr_pick(req, last_m);
                last_m    = m_port;
                exp_ack   = N'(1) << m_port;
                m_a       = op_a[32*m_port +: 32];
                m_b       = op_b[32*m_port +: 32];
                m_lat     = next_lat;
                cur_lat   = next_lat;
                m_to      = (m_lat == 0) || (m_lat > TO);
                ack_cyc   = cyc;
                rsp_cyc   = cyc + 2 + (m_to ? TO : m_lat);
                idle_from = rsp_cyc + 1;
            end
            exp_rv = (cyc == rsp_cyc) ? (N'(1) << m_port) : '0;
            if (cyc == rsp_cyc && m_to) err_m = 1'b1;

            chk("ack", 32'(ack), 32'(exp_ack));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (cyc == rsp_cyc) chk("rsp_res", rsp_res, m_to ? QNAN_C : ref_mul(m_a, m_b));
            chk("mul_ready", 32'(mul_ready), 32'(cyc == ack_cyc + 1));
            chk("mul_rst", 32'(mul_rst), 32'(cyc == rsp_cyc && m_to));
            chk("busy", 32'(busy), 32'(cyc < idle_from));
            chk("err", 32'(err), 32'(err_m));
            if (cyc >= ack_cyc && cyc <= rsp_cyc) begin
                chk("mul_op1_hold", mul_op1, m_a);
                chk("mul_op2_hold", mul_op2, m_b);
            end

            if (ack != '0) begin
                grant_log.push_back(first_bit(ack));
                ack_cyc_log.push_back(cyc);
            end
            if (rsp_valid != '0) begin
                rsp_log.push_back(rsp_res);
                rsp_port_log.push_back(first_bit(rsp_valid));
                rsp_cyc_log.push_back(cyc);
            end
            if (mul_rst) mrst_cnt++;
        end
    end

    // Requesters drop their line once acknowledged.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            req = req & ~ack;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t tbl[4];
    int   req_cyc;
    int   lat_choice[9] = '{1, 2, 3, 5, 8, 31, 32, 33, 0};

    task automatic clear_logs();
        grant_log.delete();
        ack_cyc_log.delete();
        rsp_log.delete();
        rsp_port_log.delete();
        rsp_cyc_log.delete();
    endtask

    task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #2;
        op_a[32*p +: 32] = a;
        op_b[32*p +: 32] = b;
        req[p]  = 1'b1;
        req_cyc = cyc;
    endtask

    task automatic wait_logs(input int ng, input int nr, input int budget, input string name);
        int i;
        i = 0;
        while ((grant_log.size() < ng || rsp_log.size() < nr) && i < budget) begin
            @(negedge clk);
            #3;
            i++;
        end
        chk(name, 32'(grant_log.size() >= ng && rsp_log.size() >= nr), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_res"}, rsp_res, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_mul_ready"}, 32'(mul_ready), 32'd0);
        chk({tag, "_mul_op1"}, mul_op1, 32'd0);
        chk({tag, "_mul_op2"}, mul_op2, 32'd0);
        chk({tag, "_mul_rst"}, 32'(mul_rst), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        op_a     = '0;
        op_b     = '0;
        stray    = 1'b0;
        next_lat = 3;
        cur_lat  = 3;
        tbl[0] = '{0, 32'h4000_0000, 32'h4040_0000, 3,  32'h40C0_0000, 1'b0};
        tbl[1] = '{2, 32'h7F80_0000, 32'h0000_0000, 2,  32'h7FC0_0000, 1'b0};
        tbl[2] = '{1, 32'h3FC0_0000, 32'h3FC0_0000, 32, 32'h4010_0000, 1'b0};
        tbl[3] = '{3, 32'h4000_0000, 32'h4040_0000, 1,  32'h40C0_0000, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // All four ports at once straight after reset: grants 0,1,2,3 without overlap.
        clear_logs();
        next_lat = 3;
        @(negedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            op_a[32*i +: 32] = 32'h3FC0_0000;
            op_b[32*i +: 32] = 32'h3FC0_0000;
        end
        req = '1;
        wait_logs(4, 4, 80, "all4_complete");
        for (int i = 0; i < 4; i++) begin
            chk("all4_grant_order", 32'(grant_log[i]), 32'(i));
            chk("all4_rsp_port", 32'(rsp_port_log[i]), 32'(i));
            chk("all4_rsp_res", rsp_log[i], 32'h4010_0000);
            if (i < 3) chk("all4_no_overlap", 32'(ack_cyc_log[i+1] > rsp_cyc_log[i]), 32'd1);
        end
        idle_cycles(2);

        for (int v = 0; v < 4; v++) begin
            clear_logs();
            next_lat = tbl[v].lat;
            do_req(tbl[v].port, tbl[v].a, tbl[v].b);
            wait_logs(1, 0, 10, "vec_grant_seen");
            chk("vec_grant_port", 32'(grant_log[0]), 32'(tbl[v].port));
            chk("vec_ack_latency", 32'(ack_cyc_log[0] - req_cyc), 32'd1);
            wait_logs(1, 1, 60, "vec_rsp_seen");
            chk("vec_rsp_port", 32'(rsp_port_log[0]), 32'(tbl[v].port));
            chk("vec_rsp_res", rsp_log[0], tbl[v].res);
            chk("vec_err", 32'(err), 32'(tbl[v].err));
            idle_cycles(2);
        end

        // Hung multiplier: 32 WAIT cycles, then RECOVER with mul_rst, QNAN and sticky err.
        clear_logs();
        mrst_cnt = 0;
        next_lat = 0;
        do_req(1, 32'h4000_0000, 32'h4040_0000);
        wait_logs(1, 1, 60, "hang_rsp_seen");
        chk("hang_rsp_port", 32'(rsp_port_log[0]), 32'd1);
        chk("hang_rsp_res", rsp_log[0], QNAN_C);
        chk("hang_ack_to_recover", 32'(rsp_cyc_log[0] - ack_cyc_log[0]), 32'd34);
        chk("hang_mul_rst_pulses", 32'(mrst_cnt), 32'd1);
        chk("hang_err_set", 32'(err), 32'd1);
        idle_cycles(6);
        chk("hang_err_sticky", 32'(err), 32'd1);

        // Completion arriving during RECOVER, then one arriving in IDLE, then a stray pulse.
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            next_lat = 33 + j;
            do_req(2 + j, 32'h3FC0_0000, 32'h3FC0_0000);
            wait_logs(1, 1, 60, "late_done_rsp_seen");
            chk("late_done_rsp_res", rsp_log[0], QNAN_C);
            idle_cycles(4);
            chk("late_done_single_rsp", 32'(rsp_log.size()), 32'd1);
        end
        @(negedge clk);
        #2;
        stray = 1'b1;
        @(negedge clk);
        #2;
        stray = 1'b0;
        idle_cycles(4);
        chk("stray_done_ignored", 32'(rsp_log.size()), 32'd1);
        chk("err_still_sticky", 32'(err), 32'd1);

        // Reset in the middle of WAIT aborts without a response; port 0 then works normally.
        clear_logs();
        next_lat = 20;
        do_req(0, 32'h4000_0000, 32'h4040_0000);
        wait_logs(1, 0, 10, "rstmid_grant_seen");
        idle_cycles(5);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rstmid");
        idle_cycles(2);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(25);
        chk("rstmid_no_rsp", 32'(rsp_log.size()), 32'd0);
        clear_logs();
        next_lat = 3;
        do_req(0, 32'h4000_0000, 32'h4040_0000);
        wait_logs(1, 1, 20, "rstmid_next_rsp_seen");
        chk("rstmid_next_grant", 32'(grant_log[0]), 32'd0);
        chk("rstmid_next_res", rsp_log[0], 32'h40C0_0000);
        chk("rstmid_err_cleared", 32'(err), 32'd0);
        idle_cycles(2);

        // Random traffic; operands of idle ports are scrambled to show they are ignored.
        clear_logs();
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    op_a[32*i +: 32] = $urandom();
                    op_b[32*i +: 32] = $urandom();
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end
            end
            next_lat = lat_choice[$urandom_range(8)];
        end
        begin
            int i;
            i = 0;
            while ((req != '0 || busy) && i < 600) begin
                @(negedge clk);
                #3;
                i++;
            end
            chk("random_drain", 32'(req == '0 && !busy), 32'd1);
        end
        chk("random_ack_rsp_count", 32'(rsp_log.size()), 32'(grant_log.size()));
        for (int i = 0; i < grant_log.size() && i < rsp_port_log.size(); i++) begin
            chk("random_ack_rsp_port", 32'(rsp_port_log[i]), 32'(grant_log[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
